// File: rtl/handshake_rx_ctrl.sv
// Destination-side receiver for a four-phase req/ack handshake: captures the source bus
// on request, presents it downstream, acknowledges, and tracks transfers and protocol errors.
module handshake_rx_ctrl #(
  parameter int bus_width = 8
) (
  input  logic                 dest_clk,
  input  logic                 dest_rst,
  input  logic                 req_sync,
  input  logic [bus_width-1:0] unsync_bus,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic [bus_width-1:0] sync_bus,
  output logic                 bus_enable,
  output logic                 ack,
  output logic                 proto_err,
  output logic [7:0]           xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [bus_width-1:0] sync_bus_next;
  logic                 bus_enable_next;
  logic                 ack_next;
  logic                 proto_err_next;
  logic [7:0]           xfer_cnt_next;
  logic                 err_detect;
  logic                 illegal_state;

  always_ff @(posedge dest_clk) begin
    if (!dest_rst) begin
      state      <= IDLE;
      sync_bus   <= '0;
      bus_enable <= 1'b0;
      ack        <= 1'b0;
      proto_err  <= 1'b0;
      xfer_cnt   <= 8'h00;
    end else begin
      state      <= state_next;
      sync_bus   <= sync_bus_next;
      bus_enable <= bus_enable_next;
      ack        <= ack_next;
      proto_err  <= proto_err_next;
      xfer_cnt   <= xfer_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    sync_bus_next   = sync_bus;
    bus_enable_next = bus_enable;
    ack_next        = ack;
    xfer_cnt_next   = xfer_cnt;
    err_detect      = 1'b0;
    illegal_state   = 1'b0;

    case (state)
      IDLE: begin
        bus_enable_next = 1'b0;
        ack_next        = 1'b0;
        if (req_sync) begin
          sync_bus_next   = unsync_bus;
          bus_enable_next = 1'b1;
          state_next      = HOLD;
        end
      end
      HOLD: begin
        if (req_sync && out_ready) begin
          bus_enable_next = 1'b0;
          ack_next        = 1'b1;
          xfer_cnt_next   = xfer_cnt + 8'd1;
          state_next      = ACK;
        end else if (!req_sync) begin
          // Source withdrew the request early; a simultaneous ready still delivers the data.
          err_detect      = 1'b1;
          bus_enable_next = 1'b0;
          ack_next        = 1'b0;
          if (out_ready) begin
            xfer_cnt_next = xfer_cnt + 8'd1;
          end
          state_next      = IDLE;
        end
      end
      ACK: begin
        if (!req_sync) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        illegal_state   = 1'b1;
        state_next      = IDLE;
        sync_bus_next   = '0;
        bus_enable_next = 1'b0;
        ack_next        = 1'b0;
        xfer_cnt_next   = 8'h00;
      end
    endcase

    // A newly detected error takes priority over a concurrent clear.
    if (illegal_state) begin
      proto_err_next = 1'b0;
    end else if (err_detect) begin
      proto_err_next = 1'b1;
    end else if (err_clr) begin
      proto_err_next = 1'b0;
    end else begin
      proto_err_next = proto_err;
    end
  end

endmodule

// File: tb/tb_handshake_rx_ctrl.sv
// Self-checking bench for handshake_rx_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_handshake_rx_ctrl;

  logic       dest_clk;
  logic       dest_rst;
  logic       req_sync;
  logic [7:0] unsync_bus;
  logic       out_ready;
  logic       err_clr;
  logic [7:0] sync_bus;
  logic       bus_enable;
  logic       ack;
  logic       proto_err;
  logic [7:0] xfer_cnt;

  int checks;
  int failures;

  // Reference model: whether data is being presented, whether an ack is outstanding,
  // the last captured word, a plain transfer count and the sticky error flag.
  bit         m_holding;
  bit         m_acking;
  logic [7:0] m_data;
  int         m_count;
  bit         m_err;

  handshake_rx_ctrl #(.bus_width(8)) dut (
    .dest_clk  (dest_clk),
    .dest_rst  (dest_rst),
    .req_sync  (req_sync),
    .unsync_bus(unsync_bus),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .sync_bus  (sync_bus),
    .bus_enable(bus_enable),
    .ack       (ack),
    .proto_err (proto_err),
    .xfer_cnt  (xfer_cnt)
  );

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic step(input logic r, input logic [7:0] b, input logic rdy,
                      input logic clr, input logic rs);
    bit err_set;
    @(negedge dest_clk);
    req_sync   = r;
    unsync_bus = b;
    out_ready  = rdy;
    err_clr    = clr;
    dest_rst   = rs;
    @(posedge dest_clk);
    err_set = 1'b0;
    if (!rs) begin
      m_holding = 1'b0;
      m_acking  = 1'b0;
      m_data    = 8'h00;
      m_count   = 0;
      m_err     = 1'b0;
    end else begin
      if (m_acking) begin
        if (!r) m_acking = 1'b0;
      end else if (m_holding) begin
        if (r && rdy) begin
          m_holding = 1'b0;
          m_acking  = 1'b1;
          m_count   = m_count + 1;
        end else if (!r) begin
          err_set   = 1'b1;
          m_holding = 1'b0;
          if (rdy) m_count = m_count + 1;
        end
      end else if (r) begin
        m_holding = 1'b1;
        m_data    = b;
      end
      if (err_set) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sync_bus, bus_enable, ack, proto_err, xfer_cnt} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got sync=%h en=%b ack=%b err=%b cnt=%h, want all zero",
               sync_bus, bus_enable, ack, proto_err, xfer_cnt);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    checks++;
    if (sync_bus !== 8'hA5 || bus_enable !== 1'b1 || ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_capture: got sync=%h en=%b ack=%b, want A5 1 0", sync_bus, bus_enable, ack);
    end
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ack !== 1'b1 || bus_enable !== 1'b0 || xfer_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL basic_ack: got ack=%b en=%b cnt=%h, want 1 0 01", ack, bus_enable, xfer_cnt);
    end
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ack !== 1'b1 || bus_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_ack_hold: got ack=%b en=%b, want 1 0", ack, bus_enable);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ack !== 1'b0 || bus_enable !== 1'b0 || xfer_cnt !== 8'd1 || proto_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_release: got ack=%b en=%b cnt=%h err=%b, want 0 0 01 0",
               ack, bus_enable, xfer_cnt, proto_err);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] cnt0;
    cnt0 = xfer_cnt;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
      checks++;
      if (sync_bus !== 8'h3C || bus_enable !== 1'b1 || ack !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold[%0d]: got sync=%h en=%b ack=%b, want 3C 1 0",
                 i, sync_bus, bus_enable, ack);
      end
    end
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ack !== 1'b1 || xfer_cnt !== cnt0 + 8'd1) begin
      failures++;
      $display("[TB] FAIL backpressure_release: got ack=%b cnt=%h, want 1 %h", ack, xfer_cnt, cnt0 + 8'd1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_proto_err();
    logic [7:0] cnt0;
    cnt0 = xfer_cnt;
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    checks++;
    if (proto_err !== 1'b1 || bus_enable !== 1'b0 || ack !== 1'b0 || xfer_cnt !== cnt0) begin
      failures++;
      $display("[TB] FAIL proto_err_set: got err=%b en=%b ack=%b cnt=%h, want 1 0 0 %h",
               proto_err, bus_enable, ack, xfer_cnt, cnt0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL proto_err_clear: got err=%b, want 0", proto_err);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] cnt0;
    cnt0 = xfer_cnt;
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'hC3, 1'b1, 1'b0, 1'b1);
    checks++;
    if (xfer_cnt !== cnt0 + 8'd1 || proto_err !== 1'b1 || ack !== 1'b0 || bus_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simultaneous_drop: got cnt=%h err=%b ack=%b en=%b, want %h 1 0 0",
               xfer_cnt, proto_err, ack, bus_enable, cnt0 + 8'd1);
    end
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h99, 1'b0, 1'b1, 1'b1);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL set_beats_clear: got err=%b, want 1", proto_err);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h21, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h42, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ack !== 1'b0 || bus_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL no_capture_on_ack_exit: got ack=%b en=%b, want 0 0", ack, bus_enable);
    end
    step(1'b1, 8'h42, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus_enable !== 1'b1 || sync_bus !== 8'h42) begin
      failures++;
      $display("[TB] FAIL next_capture: got en=%b sync=%h, want 1 42", bus_enable, sync_bus);
    end
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      step(1'b0, 8'(i), 1'b1, 1'b0, 1'b1);
      if (i == 254) begin
        checks++;
        if (xfer_cnt !== 8'hFF) begin
          failures++;
          $display("[TB] FAIL wrap_pre: got cnt=%h, want FF", xfer_cnt);
        end
      end
    end
    checks++;
    if (xfer_cnt !== 8'h00 || proto_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap: got cnt=%h err=%b, want 00 0", xfer_cnt, proto_err);
    end
  endtask

  task automatic test_reset_mid_ack();
    step(1'b1, 8'hE7, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hE7, 1'b1, 1'b0, 1'b1);
    #3;
    dest_rst = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_between_edges: got ack=%b, want 1", ack);
    end
    step(1'b1, 8'hE7, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({sync_bus, bus_enable, ack, proto_err, xfer_cnt} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_ack: got sync=%h en=%b ack=%b err=%b cnt=%h, want all zero",
               sync_bus, bus_enable, ack, proto_err, xfer_cnt);
    end
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus_enable !== 1'b1 || sync_bus !== 8'h77 || ack !== 1'b0 || xfer_cnt !== 8'h00) begin
      failures++;
      $display("[TB] FAIL fresh_capture: got en=%b sync=%h ack=%b cnt=%h, want 1 77 0 00",
               bus_enable, sync_bus, ack, xfer_cnt);
    end
  endtask

  task automatic test_random();
    logic r;
    r = req_sync;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) r = ~r;
      step(r, 8'($urandom), 1'($urandom), ($urandom_range(9) == 0), ($urandom_range(49) != 0));
      checks++;
      if (bus_enable !== m_holding || ack !== m_acking || sync_bus !== m_data ||
          xfer_cnt !== 8'(m_count) || proto_err !== m_err) begin
        failures++;
        $display("[TB] FAIL random[%0d]: got en=%b ack=%b sync=%h cnt=%h err=%b, want %b %b %h %h %b",
                 i, bus_enable, ack, sync_bus, xfer_cnt, proto_err,
                 m_holding, m_acking, m_data, 8'(m_count), m_err);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_holding  = 1'b0;
    m_acking   = 1'b0;
    m_data     = 8'h00;
    m_count    = 0;
    m_err      = 1'b0;
    dest_rst   = 1'b0;
    req_sync   = 1'b0;
    unsync_bus = 8'h00;
    out_ready  = 1'b0;
    err_clr    = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_proto_err();
    test_simultaneous();
    test_back_to_back();
    test_wrap();
    test_reset_mid_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_rx_ctrl.md
HANDSHAKE_RX_CTRL -- requirements
Module: handshake_rx_ctrl

Interface
REQ-001 Parameter: bus_width, default 8, width of the transferred data bus.
REQ-002 dest_clk  input  1  destination-domain clock; all state updates on its rising edge.
REQ-003 dest_rst  input  1  reset, synchronous, active-low.
REQ-004 req_sync  input  1  request level from source, already double-flop synchronized into dest_clk.
REQ-005 unsync_bus  input  bus_width  source data bus; stable by protocol while request is high.
REQ-006 out_ready  input  1  downstream can accept sync_bus this cycle.
REQ-007 err_clr  input  1  single-cycle clear of proto_err.
REQ-008 sync_bus  output  bus_width  captured data, registered.
REQ-009 bus_enable  output  1  sync_bus valid to downstream, registered.
REQ-010 ack  output  1  acknowledge level back to source (synchronized externally), registered.
REQ-011 proto_err  output  1  sticky protocol-violation flag, registered.
REQ-012 xfer_cnt  output  8  count of completed transfers, registered.

Function
REQ-013 The block SHALL implement a four-phase receive handshake FSM with states IDLE, HOLD, ACK.
REQ-014 IDLE: bus_enable=0, ack=0; req_sync=1 sampled -> sync_bus<=unsync_bus, bus_enable<=1, go HOLD.
REQ-015 Capture latency SHALL be exactly 1 cycle: req_sync high at edge k -> sync_bus/bus_enable valid after edge k.
REQ-016 HOLD: sync_bus and bus_enable SHALL hold stable until transfer or error; unsync_bus changes SHALL NOT affect sync_bus.
REQ-017 HOLD, bus_enable=1 & out_ready=1 & req_sync=1 -> bus_enable<=0, ack<=1, xfer_cnt<=xfer_cnt+1, go ACK.
REQ-018 HOLD, req_sync=0 & out_ready=0 -> proto_err<=1, bus_enable<=0, ack stays 0, xfer_cnt unchanged, go IDLE (data discarded).
REQ-019 HOLD, req_sync=0 & out_ready=1 simultaneously -> transfer counts (xfer_cnt+1), proto_err<=1, bus_enable<=0, ack stays 0, go IDLE.
REQ-020 ACK: ack=1 held; req_sync=0 sampled -> ack<=0, go IDLE; req_sync=1 -> remain ACK indefinitely.
REQ-021 A new request SHALL NOT be accepted in the cycle ACK exits; earliest next capture is the following edge with req_sync=1 in IDLE.
REQ-022 xfer_cnt SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-023 err_clr=1 SHALL clear proto_err next edge; if a new error is detected the same cycle, set wins (proto_err=1).
REQ-024 proto_err SHALL NOT alter FSM flow; the block continues handling requests while it is set.
REQ-025 Unused/illegal state encodings SHALL return to IDLE on the next edge with all outputs at reset values.

Reset
REQ-026 dest_rst=0 at a rising edge SHALL force state IDLE, sync_bus=0, bus_enable=0, ack=0, proto_err=0, xfer_cnt=0, overriding all other inputs.
REQ-027 Reset asserted mid-transfer (HOLD or ACK) SHALL abort without counting; ack drops the cycle after the reset edge.
REQ-028 Reset has no effect between clock edges (synchronous).

Verification
REQ-029 Basic: reset, req_sync=1 with unsync_bus=8'hA5, out_ready=1 -> next edge sync_bus=8'hA5, bus_enable=1; next edge ack=1, bus_enable=0, xfer_cnt=1; drop req_sync -> ack=0, IDLE.
REQ-030 Backpressure: out_ready=0 for 5 cycles in HOLD while unsync_bus toggles -> sync_bus holds 8'h3C, bus_enable=1 throughout; out_ready=1 -> ack=1, xfer_cnt+1.
REQ-031 Protocol error: req_sync drops in HOLD with out_ready=0 -> proto_err=1, bus_enable=0, ack=0, xfer_cnt unchanged; err_clr pulse -> proto_err=0.
REQ-032 Simultaneous: req_sync=0 and out_ready=1 same cycle in HOLD -> xfer_cnt+1 and proto_err=1, ack stays 0; err_clr concurrent with new error -> proto_err remains 1.
REQ-033 Wrap: 256 back-to-back transfers from reset -> xfer_cnt returns to 8'h00, no proto_err.
REQ-034 Reset mid-ACK: dest_rst=0 while ack=1 -> after the edge all outputs zero, state IDLE; holding req_sync=1 after release starts a fresh capture.
